mdu_seq: RTL and testbench

MDU_SEQ -- requirements
Module: mdu_seq

---
 rtl/mdu_seq.sv | 137 +++++++++++++
 tb/tb_mdu_seq.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_seq.sv
// Sequential multiply/divide unit: HI/LO architectural registers, shadow result
// latched at accept, committed after a fixed busy period.
module mdu_seq #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             valid,
    input  logic [3:0]       md_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic [WIDTH-1:0] rd_data,
    output logic             stall
);

    localparam int unsigned CNT_W = 5;
    localparam int unsigned DW    = 2 * WIDTH;

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0] sh_hi_q, sh_hi_d, sh_lo_q, sh_lo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic mdu_op_c, accept_c;

    assign mdu_op_c = (md_op >= OP_MULT) && (md_op <= OP_MTLO);
    assign busy     = (cnt_q != '0);
    assign accept_c = valid & ~busy & mdu_op_c;
    assign stall    = valid & mdu_op_c & busy;
    assign hi       = hi_q;
    assign lo       = lo_q;

    // Full-width products
    logic signed [DW-1:0] a_ext_c, b_ext_c, prod_s_c;
    logic [DW-1:0]        prod_u_c;

    assign a_ext_c  = $signed({{WIDTH{a[WIDTH-1]}}, a});
    assign b_ext_c  = $signed({{WIDTH{b[WIDTH-1]}}, b});
    assign prod_s_c = a_ext_c * b_ext_c;
    assign prod_u_c = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

    // Divisor forced to 1 for b=0 and MIN/-1: MIN/1 yields the required MIN, 0 result
    logic                    div_zero_c, div_ovf_c;
    logic [WIDTH-1:0]        divs_c, divu_c;
    logic signed [WIDTH-1:0] quo_s_c, rem_s_c;
    logic [WIDTH-1:0]        quo_u_c, rem_u_c;

    assign div_zero_c = (b == '0);
    assign div_ovf_c  = (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
    assign divs_c     = (div_zero_c || div_ovf_c) ? WIDTH'(1) : b;
    assign divu_c     = div_zero_c ? WIDTH'(1) : b;
    assign quo_s_c    = $signed(a) / $signed(divs_c);
    assign rem_s_c    = $signed(a) % $signed(divs_c);
    assign quo_u_c    = a / divu_c;
    assign rem_u_c    = a % divu_c;

    // Next-state: countdown/commit, then accept (mutually exclusive with busy)
    always_comb begin
        hi_d    = hi_q;
        lo_d    = lo_q;
        sh_hi_d = sh_hi_q;
        sh_lo_d = sh_lo_q;
        cnt_d   = cnt_q;
        if (busy) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                hi_d = sh_hi_q;
                lo_d = sh_lo_q;
            end
        end
        if (accept_c) begin
            case (md_op)
                OP_MULT: begin
                    {sh_hi_d, sh_lo_d} = prod_s_c;
                    cnt_d              = CNT_W'(MULT_CYCLES);
                end
                OP_MULTU: begin
                    {sh_hi_d, sh_lo_d} = prod_u_c;
                    cnt_d              = CNT_W'(MULT_CYCLES);
                end
                OP_DIV: begin
                    cnt_d   = CNT_W'(DIV_CYCLES);
                    sh_hi_d = div_zero_c ? hi_q : rem_s_c;
                    sh_lo_d = div_zero_c ? lo_q : quo_s_c;
                end
                OP_DIVU: begin
                    cnt_d   = CNT_W'(DIV_CYCLES);
                    sh_hi_d = div_zero_c ? hi_q : rem_u_c;
                    sh_lo_d = div_zero_c ? lo_q : quo_u_c;
                end
                OP_MTHI: hi_d = a;
                OP_MTLO: lo_d = a;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hi_q    <= '0;
            lo_q    <= '0;
            sh_hi_q <= '0;
            sh_lo_q <= '0;
            cnt_q   <= '0;
        end else begin
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            sh_hi_q <= sh_hi_d;
            sh_lo_q <= sh_lo_d;
            cnt_q   <= cnt_d;
        end
    end

    // Move-from read port
    always_comb begin
        rd_data = '0;
        if (md_op == OP_MFHI) begin
            rd_data = hi_q;
        end else if (md_op == OP_MFLO) begin
            rd_data = lo_q;
        end
    end

endmodule

// File: tb/tb_mdu_seq.sv
// Self-checking bench for mdu_seq: directed cases plus random ops against a
// cycle-level reference model using 64-bit arithmetic.
module tb_mdu_seq;

    localparam int unsigned W    = 32;
    localparam int unsigned MULT = 5;
    localparam int unsigned DIVC = 10;

    logic         clk;
    logic         reset_n;
    logic         valid;
    logic [3:0]   md_op;
    logic [W-1:0] a, b;
    logic [W-1:0] hi, lo, rd_data;
    logic         busy, stall;

    mdu_seq #(.WIDTH(W), .MULT_CYCLES(MULT), .DIV_CYCLES(DIVC)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .valid   (valid),
        .md_op   (md_op),
        .a       (a),
        .b       (b),
        .hi      (hi),
        .lo      (lo),
        .busy    (busy),
        .rd_data (rd_data),
        .stall   (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [31:0] m_hi, m_lo, m_pend_hi, m_pend_lo;
    bit          m_pend_ok;
    int          m_cnt;
    logic        last_stall;
    logic [31:0] last_rd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_hi = '0; m_lo = '0; m_pend_hi = '0; m_pend_lo = '0;
        m_pend_ok = 1'b0; m_cnt = 0;
    endtask

    task automatic model_edge(input logic v, input logic [3:0] op,
                              input logic [31:0] av, input logic [31:0] bv);
        bit          acc;
        longint      sa, sb, q, r;
        logic [63:0] p;
        if (!reset_n) begin
            model_reset();
            return;
        end
        acc = v && (m_cnt == 0) && (op >= 4'd1) && (op <= 4'd8);
        if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0 && m_pend_ok) begin
                m_hi = m_pend_hi;
                m_lo = m_pend_lo;
            end
        end
        if (acc) begin
            case (op)
                4'd1: begin
                    p = 64'(longint'($signed(av)) * longint'($signed(bv)));
                    m_pend_hi = p[63:32]; m_pend_lo = p[31:0];
                    m_pend_ok = 1'b1; m_cnt = MULT;
                end
                4'd2: begin
                    p = {32'd0, av} * {32'd0, bv};
                    m_pend_hi = p[63:32]; m_pend_lo = p[31:0];
                    m_pend_ok = 1'b1; m_cnt = MULT;
                end
                4'd3: begin
                    m_cnt = DIVC;
                    m_pend_ok = (bv != 0);
                    if (bv != 0) begin
                        sa = longint'($signed(av));
                        sb = longint'($signed(bv));
                        q = sa / sb;
                        r = sa % sb;
                        m_pend_lo = q[31:0];
                        m_pend_hi = r[31:0];
                    end
                end
                4'd4: begin
                    m_cnt = DIVC;
                    m_pend_ok = (bv != 0);
                    if (bv != 0) begin
                        m_pend_lo = av / bv;
                        m_pend_hi = av % bv;
                    end
                end
                4'd7: m_hi = av;
                4'd8: m_lo = av;
                default: ;
            endcase
        end
    endtask

    // One clock: drive, check combinational outputs, clock, check registered state
    task automatic cyc(input logic v, input logic [3:0] op,
                       input logic [31:0] av, input logic [31:0] bv);
        logic exp_stall;
        logic [31:0] exp_rd;
        @(negedge clk);
        valid = v; md_op = op; a = av; b = bv;
        #1;
        exp_stall = v && (op >= 4'd1) && (op <= 4'd8) && (m_cnt != 0);
        exp_rd    = (op == 4'd5) ? m_hi : (op == 4'd6) ? m_lo : 32'd0;
        chk("busy_pre", 32'(busy), 32'(m_cnt != 0));
        chk("stall", 32'(stall), 32'(exp_stall));
        chk("rd_data", rd_data, exp_rd);
        last_stall = stall;
        last_rd    = rd_data;
        @(posedge clk);
        model_edge(v, op, av, bv);
        #1;
        chk("hi", hi, m_hi);
        chk("lo", lo, m_lo);
        chk("busy_post", 32'(busy), 32'(m_cnt != 0));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 4'd0, 32'd0, 32'd0);
    endtask

    initial begin
        int          n;
        logic [3:0]  rop;
        logic [31:0] ra, rb;

        reset_n = 1'b0; valid = 1'b0; md_op = 4'd0; a = '0; b = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Signed and unsigned multiply
        cyc(1'b1, 4'd1, 32'hFFFF_FFFF, 32'd2);
        idle(MULT);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFFE);
        cyc(1'b1, 4'd2, 32'hFFFF_FFFF, 32'd2);
        idle(MULT);
        chk("multu_hi", hi, 32'h0000_0001);
        chk("multu_lo", lo, 32'hFFFF_FFFE);

        // Signed divide, including MIN / -1
        cyc(1'b1, 4'd3, 32'hFFFF_FFF9, 32'd2);
        idle(DIVC);
        chk("div_lo", lo, 32'hFFFF_FFFD);
        chk("div_hi", hi, 32'hFFFF_FFFF);
        cyc(1'b1, 4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        idle(DIVC);
        chk("divovf_lo", lo, 32'h8000_0000);
        chk("divovf_hi", hi, 32'd0);

        // Divide by zero leaves HI/LO alone
        cyc(1'b1, 4'd7, 32'h11, 32'd0);
        cyc(1'b1, 4'd8, 32'h22, 32'd0);
        cyc(1'b1, 4'd4, 32'h1234, 32'd0);
        idle(DIVC);
        chk("div0_hi", hi, 32'h11);
        chk("div0_lo", lo, 32'h22);

        // mflo behind a mult stalls for the busy period, then reads the new LO
        cyc(1'b1, 4'd1, 32'd3, 32'd5);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            cyc(1'b1, 4'd6, 32'd0, 32'd0);
            if (!last_stall) break;
            n++;
        end
        chk("stall_len", 32'(n), 32'(MULT));
        chk("mflo_after_stall", last_rd, 32'd15);

        // Non-MDU op, invalid op codes and valid=0 during/around busy
        cyc(1'b1, 4'd2, 32'd7, 32'd9);
        cyc(1'b1, 4'd0, 32'd1, 32'd1);
        cyc(1'b1, 4'd12, 32'd1, 32'd1);
        cyc(1'b0, 4'd7, 32'hDEAD, 32'd0);
        cyc(1'b1, 4'd7, 32'hBEEF, 32'd0);
        idle(MULT);
        cyc(1'b0, 4'd1, 32'd5, 32'd5);
        cyc(1'b1, 4'd15, 32'd5, 32'd5);

        // mthi followed immediately by mfhi
        cyc(1'b1, 4'd7, 32'h1234, 32'd0);
        cyc(1'b1, 4'd5, 32'd0, 32'd0);
        chk("mfhi_rd", last_rd, 32'h1234);
        chk("mfhi_nostall", 32'(last_stall), 32'd0);

        // Reset mid-divide abandons the result
        cyc(1'b1, 4'd4, 32'd100, 32'd7);
        idle(2);
        reset_n = 1'b0;
        cyc(1'b0, 4'd0, 32'd0, 32'd0);
        reset_n = 1'b1;
        chk("rst_mid_busy", 32'(busy), 32'd0);
        idle(DIVC + 2);
        chk("rst_mid_hi", hi, 32'd0);
        chk("rst_mid_lo", lo, 32'd0);

        // Random traffic with corner operands and occasional reset
        for (int i = 0; i < 600; i++) begin
            rop = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(9, 15))
                                              : 4'($urandom_range(0, 8));
            ra  = $urandom();
            rb  = $urandom();
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: ra = 32'h8000_0000;
                3: rb = 32'($urandom_range(1, 16));
                default: ;
            endcase
            reset_n = ($urandom_range(0, 99) != 0);
            cyc(($urandom_range(0, 3) != 0), rop, ra, rb);
        end
        reset_n = 1'b1;
        idle(DIVC + 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
